// File: rtl/cmd_fetch.sv
// Instruction fetch stage: prefetches 64-bit words into a small FIFO and presents them
// half by half on dc_o/tkk_o. Define FETCH_BYPASS_EN to let an ack load dc_o directly.
module cmd_fetch #(
    parameter int unsigned AW    = 20,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic          mem_ack_i,
    input  logic [63:0]   mem_rdata_i,
    input  logic          jump_i,
    input  logic [AW-1:0] jump_addr_i,
    input  logic          jump_right_i,
    input  logic          advance_i,
    output logic [63:0]   dc_o,
    output logic          tkk_o,
    output logic          valid_o,
    output logic [AW-1:0] pc_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    // FIFO storage and pointers
    logic [AW+63:0]   fifo_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // Request side
    logic             req_q, req_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    fptr_q, fptr_d;
    logic             discard_q, discard_d;
    logic             started_q, started_d;

    // Presentation register
    logic [63:0]      dc_q, dc_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic             tkk_q, tkk_d;
    logic             valid_q, valid_d;

    logic             ack, hold, push, pop, bypass_load, need_word, fifo_empty, issue;
    logic [AW-1:0]    next_ptr;
    logic [AW+63:0]   head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        ack         = req_q & mem_ack_i;
        hold        = req_q & ~mem_ack_i;
        fifo_empty  = (cnt_q == '0);
        head        = fifo_q[rd_ptr_q];
        bypass_load = 1'b0;
`ifdef FETCH_BYPASS_EN
        bypass_load = ~jump_i & ~valid_q & fifo_empty & ack & ~discard_q;
`else
        bypass_load = 1'b0;
`endif
        // Acked data is dropped when discarding a stale request or on a coincident jump.
        push      = ack & ~discard_q & ~jump_i & ~bypass_load;
        need_word = ~valid_q | (advance_i & tkk_q);
        pop       = ~jump_i & need_word & ~fifo_empty;
    end

    // FIFO bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (jump_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d = cnt_q + CntW'(push) - CntW'(pop);
        end
    end

    // Request sequencing: at most one request outstanding, occupancy bounded by DEPTH
    always_comb begin
        started_d = started_q | jump_i;
        next_ptr  = jump_i ? jump_addr_i : fptr_q;
        issue     = started_d & ~hold & (cnt_d < CntW'(DEPTH));
        req_d     = hold | issue;
        addr_d    = issue ? next_ptr : addr_q;
        fptr_d    = issue ? next_ptr + AW'(1) : next_ptr;
        discard_d = discard_q;
        if (jump_i && hold) begin
            discard_d = 1'b1;
        end else if (ack) begin
            discard_d = 1'b0;
        end
    end

    // Presentation: left half, right half, then the next word
    always_comb begin
        dc_d    = dc_q;
        pc_d    = pc_q;
        tkk_d   = tkk_q;
        valid_d = valid_q;
        if (jump_i) begin
            valid_d = 1'b0;
            tkk_d   = jump_right_i;
        end else if (!valid_q) begin
            if (pop) begin
                dc_d    = head[63:0];
                pc_d    = head[AW+63:64];
                valid_d = 1'b1;
            end else if (bypass_load) begin
                dc_d    = mem_rdata_i;
                pc_d    = addr_q;
                valid_d = 1'b1;
            end
        end else if (advance_i) begin
            if (!tkk_q) begin
                tkk_d = 1'b1;
            end else begin
                tkk_d = 1'b0;
                if (pop) begin
                    dc_d = head[63:0];
                    pc_d = head[AW+63:64];
                end else begin
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {addr_q, mem_rdata_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            fptr_q    <= '0;
            discard_q <= 1'b0;
            started_q <= 1'b0;
            dc_q      <= '0;
            pc_q      <= '0;
            tkk_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            fptr_q    <= fptr_d;
            discard_q <= discard_d;
            started_q <= started_d;
            dc_q      <= dc_d;
            pc_q      <= pc_d;
            tkk_q     <= tkk_d;
            valid_q   <= valid_d;
        end
    end

    assign mem_req_o  = req_q;
    assign mem_addr_o = addr_q;
    assign dc_o       = dc_q;
    assign pc_o       = pc_q;
    assign tkk_o      = tkk_q;
    assign valid_o    = valid_q;

endmodule

// File: tb/tb_cmd_fetch.sv
// Bench for cmd_fetch: address-derived memory responder, a half-stream model checked every
// cycle, and directed scenarios with literal expectations.
module tb_cmd_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        jump;
    logic [19:0] jump_addr;
    logic        jump_right;
    logic        advance;
    logic [63:0] dc;
    logic        tkk;
    logic        valid;
    logic [19:0] pc;

    int vectors = 0;
    int miscompares = 0;

    logic stall = 1'b0;
    int   ack_dly = 0;
    int   acks = 0;
    logic [19:0] ack_log[$];

    cmd_fetch #(.AW(20), .DEPTH(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata),
        .jump_i      (jump),
        .jump_addr_i (jump_addr),
        .jump_right_i(jump_right),
        .advance_i   (advance),
        .dc_o        (dc),
        .tkk_o       (tkk),
        .valid_o     (valid),
        .pc_o        (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [19:0] a);
        return {12'hA5C, a, 12'h3E1, ~a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks after ack_dly waiting cycles unless stalled
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && mem_req && !stall) begin
                if (wait_cnt >= ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    wait_cnt  = 0;
                end else begin
                    mem_ack  = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Model: expected half stream and expected request address sequence, checked just
    // before every rising edge with the inputs that edge will consume.
    initial begin
        logic [19:0] exp_pc, exp_req, prev_addr;
        logic        exp_tkk, started_m, discard_m, prev_hold;
        exp_pc = '0; exp_req = '0; prev_addr = '0;
        exp_tkk = 1'b0; started_m = 1'b0; discard_m = 1'b0; prev_hold = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                started_m = 1'b0;
                discard_m = 1'b0;
                prev_hold = 1'b0;
                chk("reset_outputs", {mem_req, valid, tkk, pc, mem_addr}, '0);
                chk("reset_dc", dc, '0);
                continue;
            end
            if (!started_m) begin
                chk("idle_outputs", {mem_req, valid, tkk, pc}, '0);
            end
            if (prev_hold) begin
                chk("req_stable", {mem_req, mem_addr}, {1'b1, prev_addr});
            end
            if (valid) begin
                chk("pc", pc, exp_pc);
                chk("tkk", tkk, exp_tkk);
                chk("dc", dc, mem_word(exp_pc));
            end
            if (mem_req && mem_ack) begin
                acks++;
                ack_log.push_back(mem_addr);
                if (discard_m) begin
                    discard_m = 1'b0;
                end else begin
                    chk("req_addr", mem_addr, exp_req);
                    exp_req = exp_req + 20'd1;
                end
            end
            prev_hold = mem_req && !mem_ack;
            prev_addr = mem_addr;
            if (jump) begin
                started_m = 1'b1;
                exp_pc    = jump_addr;
                exp_tkk   = jump_right;
                exp_req   = jump_addr;
                if (mem_req && !mem_ack) discard_m = 1'b1;
            end else if (valid && advance) begin
                if (!exp_tkk) begin
                    exp_tkk = 1'b1;
                end else begin
                    exp_tkk = 1'b0;
                    exp_pc  = exp_pc + 20'd1;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; jump = 1'b0; advance = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_jump(input logic [19:0] a, input logic right);
        @(negedge clk);
        jump = 1'b1; jump_addr = a; jump_right = right;
        @(negedge clk);
        jump = 1'b0; jump_right = 1'b0;
    endtask

    task automatic do_advance();
        @(negedge clk);
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
    endtask

    // Returns the number of falling edges seen since the caller's edge until valid
    task automatic wait_valid(input string name, input int limit, output int n);
        n = 1;
        while (!valid && n <= limit) begin
            @(negedge clk);
            n++;
        end
        if (!valid) chk({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    localparam int ExpLat =
`ifdef FETCH_BYPASS_EN
        2;
`else
        3;
`endif

    initial begin
        int n, mark;
        rst_n = 1'b0; jump = 1'b0; jump_addr = '0; jump_right = 1'b0; advance = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: idle after reset
        repeat (20) @(negedge clk);
        chk("t1_idle", {mem_req, valid, tkk, pc}, '0);

        // 2: plain fetch and half sequencing
        mark = ack_log.size();
        do_jump(20'h00100, 1'b0);
        wait_valid("t2_valid", 10, n);
        chk("t2_latency", n, ExpLat);
        chk("t2_dc_a", dc, 64'hA5C00100_3E1FFEFF);
        chk("t2_pc_tkk", {pc, tkk}, {20'h00100, 1'b0});
        do_advance();
        chk("t2_tkk1", {valid, tkk, pc}, {1'b1, 1'b1, 20'h00100});
        do_advance();
        wait_valid("t2_valid_b", 5, n);
        chk("t2_dc_b", dc, 64'hA5C00101_3E1FFEFE);
        chk("t2_pc_b", {pc, tkk}, {20'h00101, 1'b0});
        chk("t2_req_seq", {ack_log[mark], ack_log[mark+1], ack_log[mark+2]},
            {20'h00100, 20'h00101, 20'h00102});

        // 3: jump mid-stream, start at right half
        do_jump(20'h00200, 1'b1);
        wait_valid("t3_valid", 10, n);
        chk("t3_latency", n, ExpLat);
        chk("t3_first", {pc, tkk}, {20'h00200, 1'b1});
        do_advance();
        wait_valid("t3_valid2", 5, n);
        chk("t3_second", {pc, tkk}, {20'h00201, 1'b0});

        // 4: jump while a request is pending, data of that request is discarded
        do_reset();
        stall = 1'b1;
        do_jump(20'h00105, 1'b0);
        repeat (3) @(negedge clk);
        chk("t4_pending", {mem_req, mem_addr}, {1'b1, 20'h00105});
        do_jump(20'h00300, 1'b0);
        chk("t4_held", {mem_req, mem_addr}, {1'b1, 20'h00105});
        mark = ack_log.size();
        stall = 1'b0;
        wait_valid("t4_valid", 10, n);
        chk("t4_pc", pc, 20'h00300);
        chk("t4_req_seq", {ack_log[mark], ack_log[mark+1]}, {20'h00105, 20'h00300});

        // 4b: back-to-back jumps, last one wins
        do_reset();
        stall = 1'b1;
        @(negedge clk);
        jump = 1'b1; jump_addr = 20'h00400;
        @(negedge clk);
        jump_addr = 20'h00410;
        @(negedge clk);
        jump = 1'b0;
        mark = ack_log.size();
        stall = 1'b0;
        wait_valid("t4b_valid", 10, n);
        chk("t4b_pc", {pc, tkk}, {20'h00410, 1'b0});
        chk("t4b_req_seq", {ack_log[mark], ack_log[mark+1]}, {20'h00400, 20'h00410});

        // 5: prefetch depth bounds the number of requests
        do_reset();
        mark = acks;
        do_jump(20'h00600, 1'b0);
        wait_valid("t5_valid", 10, n);
        repeat (20) @(negedge clk);
        chk("t5_req_count", acks - mark, 3);
        chk("t5_req_idle", mem_req, 1'b0);
        do_advance();
        do_advance();
        n = 0;
        while (!mem_req && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("t5_req_again", mem_req, 1'b1);

        // 6: address wrap with slow memory
        do_reset();
        ack_dly = 2;
        mark = ack_log.size();
        do_jump(20'hFFFFF, 1'b0);
        wait_valid("t6_valid", 20, n);
        chk("t6_pc_top", pc, 20'hFFFFF);
        do_advance();
        do_advance();
        wait_valid("t6_valid2", 20, n);
        chk("t6_pc_wrap", {pc, tkk}, {20'h00000, 1'b0});
        chk("t6_req_seq", {ack_log[mark], ack_log[mark+1]}, {20'hFFFFF, 20'h00000});
        ack_dly = 0;

        // Reset in the middle of a pending request
        stall = 1'b1;
        do_jump(20'h00700, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid", {mem_req, valid, pc}, '0);
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst_mid_idle", {mem_req, valid}, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
